// File: rtl/mul_pkg.sv
// Shared encodings for the sequential multiplier.
// Op codes follow the RV32M/RV64M funct3 low bits.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL_OP_MUL    = 2'b00,
    MUL_OP_MULH   = 2'b01,
    MUL_OP_MULHSU = 2'b10,
    MUL_OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } mul_state_e;

  function automatic int mul_steps(
    input int xlen,
    input int unroll
  );
    return xlen / unroll;
  endfunction

endpackage

// File: rtl/mul_step.sv
// One add-shift step retiring UNROLL multiplier bits.
// Upper XLEN+UNROLL bits accumulate; low bits hold the multiplier.
module mul_step #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic [2*XLEN+UNROLL-1:0] acc,
  input  logic [XLEN-1:0]          mcand,
  output logic [2*XLEN+UNROLL-1:0] acc_next
);

  localparam int W  = 2*XLEN + UNROLL;
  localparam int HW = XLEN + UNROLL;

  logic [HW-1:0] hi;
  logic [HW-1:0] part;
  logic [HW-1:0] sum;
  logic [W-1:0]  cat;

  // hi stays below 2^XLEN after each shift, so sum cannot overflow HW
  always_comb begin
    part     = HW'(mcand) * HW'(acc[UNROLL-1:0]);
    hi       = acc[W-1:XLEN];
    sum      = hi + part;
    cat      = {sum, acc[XLEN-1:0]};
    acc_next = cat >> UNROLL;
  end

endmodule

// File: rtl/mul_seq.sv
// Sequential MUL/MULH/MULHSU/MULHU unit for the execute stage.
// Multiplies magnitudes, then fixes the sign in a separate cycle.
module mul_seq
  import mul_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input  logic            clk_in,
  input  logic            reset_n_in,
  input  logic            req_in,
  input  logic            flush_in,
  input  logic [1:0]      op_in,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [XLEN-1:0] result_out
);

  localparam int N  = mul_steps(XLEN, UNROLL);
  localparam int CW = $clog2(N + 1);
  localparam int PW = 2*XLEN + UNROLL;

  if (!(XLEN == 32 || XLEN == 64)) begin : g_xlen_chk
    $error("mul_seq: XLEN must be 32 or 64");
  end
  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)
      || (XLEN % UNROLL) != 0) begin : g_unroll_chk
    $error("mul_seq: UNROLL must be 1/2/4 and divide XLEN");
  end

  mul_state_e state_q, state_d;

  logic [1:0]        op_q;
  logic              neg_q;
  logic [XLEN-1:0]   mag_a_q;
  logic [CW-1:0]     cnt_q;
  logic [PW-1:0]     prod_q;
  logic [PW-1:0]     prod_step;
  logic [2*XLEN-1:0] prod_fix;
  logic              sign_a;
  logic              sign_b;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic              zero_in;
  logic              accept;
  logic              last;

  mul_step #(
    .XLEN  (XLEN),
    .UNROLL(UNROLL)
  ) u_step (
    .acc     (prod_q),
    .mcand   (mag_a_q),
    .acc_next(prod_step)
  );

  always_comb begin
    sign_a  = (op_in != MUL_OP_MULHU) && a_in[XLEN-1];
    sign_b  = (op_in == MUL_OP_MUL || op_in == MUL_OP_MULH)
              && b_in[XLEN-1];
    mag_a   = sign_a ? -a_in : a_in;
    mag_b   = sign_b ? -b_in : b_in;
    zero_in = (a_in == '0) || (b_in == '0);
    accept  = (state_q == S_IDLE) && req_in && !flush_in;
    last    = (cnt_q == CW'(1));
    prod_fix = neg_q ? -prod_q[2*XLEN-1:0]
                     :  prod_q[2*XLEN-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (accept) state_d = zero_in ? S_DONE : S_CALC;
      S_CALC: if (last) state_d = S_FIX;
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_in) state_d = S_IDLE;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) state_q <= S_IDLE;
    else             state_q <= state_d;
  end

  // result is loaded on the edge into DONE so it is valid with done_out
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      op_q       <= '0;
      neg_q      <= 1'b0;
      mag_a_q    <= '0;
      cnt_q      <= '0;
      prod_q     <= '0;
      busy_out   <= 1'b0;
      done_out   <= 1'b0;
      result_out <= '0;
    end else begin
      busy_out <= (state_d != S_IDLE);
      done_out <= (state_d == S_DONE);
      if (accept) begin
        op_q    <= op_in;
        neg_q   <= sign_a ^ sign_b;
        mag_a_q <= mag_a;
        cnt_q   <= CW'(N);
        prod_q  <= zero_in ? '0 : {(XLEN+UNROLL)'(0), mag_b};
        if (zero_in) result_out <= '0;
      end else if (state_q == S_CALC && !flush_in) begin
        prod_q <= prod_step;
        cnt_q  <= cnt_q - CW'(1);
      end else if (state_q == S_FIX && !flush_in) begin
        prod_q     <= {UNROLL'(0), prod_fix};
        result_out <= (op_q == MUL_OP_MUL) ? prod_fix[XLEN-1:0]
                                           : prod_fix[2*XLEN-1:XLEN];
      end
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: directed table on XLEN=32/UNROLL=1,
// plus model sweeps on UNROLL=2 and XLEN=64/UNROLL=4.
module tb_mul_seq;

  logic clk;
  logic rst_n;
  logic flush_off;

  logic        req0, flush0, busy0, done0;
  logic [1:0]  op0;
  logic [31:0] a0, b0, res0;

  logic        req1, busy1, done1;
  logic [1:0]  op1;
  logic [31:0] a1, b1, res1;

  logic        req2, busy2, done2;
  logic [1:0]  op2;
  logic [63:0] a2, b2, res2;

  int pass_cnt;
  int total_cnt;

  mul_seq #(.XLEN(32), .UNROLL(1)) u0 (
    .clk_in(clk), .reset_n_in(rst_n),
    .req_in(req0), .flush_in(flush0), .op_in(op0),
    .a_in(a0), .b_in(b0),
    .busy_out(busy0), .done_out(done0), .result_out(res0)
  );

  mul_seq #(.XLEN(32), .UNROLL(2)) u1 (
    .clk_in(clk), .reset_n_in(rst_n),
    .req_in(req1), .flush_in(flush_off), .op_in(op1),
    .a_in(a1), .b_in(b1),
    .busy_out(busy1), .done_out(done1), .result_out(res1)
  );

  mul_seq #(.XLEN(64), .UNROLL(4)) u2 (
    .clk_in(clk), .reset_n_in(rst_n),
    .req_in(req2), .flush_in(flush_off), .op_in(op2),
    .a_in(a2), .b_in(b2),
    .busy_out(busy2), .done_out(done2), .result_out(res2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, got, exp);
  endtask

  function automatic logic [31:0] ref32(input logic [1:0] op,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [65:0] sa, sb, p;
    sa = (op != 2'b11 && a[31]) ? {{34{1'b1}}, a} : {34'b0, a};
    sb = (op[1] == 1'b0 && b[31]) ? {{34{1'b1}}, b} : {34'b0, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [63:0] ref64(input logic [1:0] op,
                                        input logic [63:0] a,
                                        input logic [63:0] b);
    logic signed [129:0] sa, sb, p;
    sa = (op != 2'b11 && a[63]) ? {{66{1'b1}}, a} : {66'b0, a};
    sb = (op[1] == 1'b0 && b[63]) ? {{66{1'b1}}, b} : {66'b0, b};
    p  = sa * sb;
    return (op == 2'b00) ? p[63:0] : p[127:64];
  endfunction

  task automatic issue(input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    op0 = op; a0 = a; b0 = b; req0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0;
  endtask

  task automatic watch(input int ncyc, input int req_at,
                       input int flush_at, output int lat,
                       output logic [31:0] res, output int np,
                       output logic bz1, output logic bzf);
    lat = -1; res = res0; np = 0; bz1 = 1'b0; bzf = 1'b1;
    for (int k = 1; k <= ncyc; k++) begin
      @(negedge clk);
      if (k == 1) bz1 = busy0;
      if (k == flush_at + 1) bzf = busy0;
      if (done0) begin
        np++;
        if (lat < 0) begin lat = k; res = res0; end
      end
      flush0 = (k == flush_at);
      if (k == req_at) begin
        req0 = 1'b1; a0 = 32'h9; b0 = 32'h9;
      end
      if (k == req_at + 3) req0 = 1'b0;
    end
    if (lat < 0) res = res0;
    flush0 = 1'b0; req0 = 1'b0;
  endtask

  task automatic run1(input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    int lat;
    logic [31:0] res;
    logic bz;
    @(negedge clk);
    op1 = op; a1 = a; b1 = b; req1 = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    lat = -1; res = '0; bz = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) bz = busy1;
      if (done1 && lat < 0) begin lat = k; res = res1; end
    end
    chk("u1_busy", 64'(bz), 64'(1));
    chk("u1_lat", 64'(lat), 64'((a == 0 || b == 0) ? 1 : 18));
    chk("u1_res", 64'(res), 64'(ref32(op, a, b)));
  endtask

  task automatic run2(input logic [1:0] op, input logic [63:0] a,
                      input logic [63:0] b);
    int lat;
    logic [63:0] res;
    logic bz;
    @(negedge clk);
    op2 = op; a2 = a; b2 = b; req2 = 1'b1;
    @(posedge clk);
    #1;
    req2 = 1'b0;
    lat = -1; res = '0; bz = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (k == 1) bz = busy2;
      if (done2 && lat < 0) begin lat = k; res = res2; end
    end
    chk("u2_busy", 64'(bz), 64'(1));
    chk("u2_lat", 64'(lat), 64'((a == 0 || b == 0) ? 1 : 18));
    chk("u2_res", res, ref64(op, a, b));
  endtask

  initial begin
    int lat, np;
    logic [31:0] res;
    logic bz1, bzf;
    logic [1:0] rop;
    logic [63:0] ra, rb;

    pass_cnt = 0; total_cnt = 0;
    clk = 1'b0; rst_n = 1'b0; flush_off = 1'b0;
    req0 = 0; flush0 = 0; op0 = 0; a0 = 0; b0 = 0;
    req1 = 0; op1 = 0; a1 = 0; b1 = 0;
    req2 = 0; op2 = 0; a2 = 0; b2 = 0;

    vt[0]  = '{2'b00, 32'd7,         32'd6,         32'h0000_002A, 34};
    vt[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34};
    vt[2]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 34};
    vt[3]  = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
    vt[4]  = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
    vt[5]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34};
    vt[6]  = '{2'b00, 32'h0,         32'h1234_5678, 32'h0000_0000, 1};
    vt[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 34};
    vt[8]  = '{2'b10, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 34};
    vt[9]  = '{2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 34};
    vt[10] = '{2'b00, 32'h1234_5678, 32'h10,        32'h2345_6780, 34};
    vt[11] = '{2'b11, 32'h1234_5678, 32'h10,        32'h0000_0001, 34};
    vt[12] = '{2'b00, 32'hFFFF_FFFF, 32'd5,         32'hFFFF_FFFB, 34};
    vt[13] = '{2'b11, 32'h1234_5678, 32'h0,         32'h0000_0000, 1};

    #12;
    chk("rst_busy", 64'(busy0), 64'(0));
    chk("rst_done", 64'(done0), 64'(0));
    chk("rst_res", 64'(res0), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b);
      watch(38, 0, 0, lat, res, np, bz1, bzf);
      chk($sformatf("v%0d_lat", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("v%0d_res", i), 64'(res), 64'(vt[i].exp));
      chk($sformatf("v%0d_pulses", i), 64'(np), 64'(1));
      chk($sformatf("v%0d_busy", i), 64'(bz1), 64'(1));
    end

    // request while busy is dropped, only one result comes back
    issue(2'b00, 32'd3, 32'd5);
    watch(40, 5, 0, lat, res, np, bz1, bzf);
    chk("busyreq_lat", 64'(lat), 64'(34));
    chk("busyreq_res", 64'(res), 64'hF);
    chk("busyreq_pulses", 64'(np), 64'(1));

    // flush in CALC cycle 10: no done, busy drops, result holds
    issue(2'b00, 32'd11, 32'd13);
    watch(40, 0, 10, lat, res, np, bz1, bzf);
    chk("flush_pulses", 64'(np), 64'(0));
    chk("flush_busy", 64'(bzf), 64'(0));
    chk("flush_res", 64'(res0), 64'hF);

    issue(2'b11, 32'hFFFF_FFFF, 32'd2);
    watch(38, 0, 0, lat, res, np, bz1, bzf);
    chk("postflush_lat", 64'(lat), 64'(34));
    chk("postflush_res", 64'(res), 64'(1));

    // async reset mid-CALC clears outputs at once
    issue(2'b00, 32'd3, 32'd5);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy0), 64'(0));
    chk("midrst_done", 64'(done0), 64'(0));
    chk("midrst_res", 64'(res0), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    issue(2'b00, 32'd7, 32'd6);
    watch(38, 0, 0, lat, res, np, bz1, bzf);
    chk("afterrst_lat", 64'(lat), 64'(34));
    chk("afterrst_res", 64'(res), 64'h2A);

    run1(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run1(2'b01, 32'h8000_0000, 32'h8000_0000);
    for (int i = 0; i < 8; i++) begin
      rop = 2'(i);
      run1(rop, $urandom, $urandom);
    end

    run2(2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run2(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    run2(2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
    run2(2'b00, 64'h0, 64'h1234_5678);
    for (int i = 0; i < 8; i++) begin
      rop = 2'(i);
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      run2(rop, ra, rb);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
